// File: rtl/rvfi_retire_reorder.sv
// -----------------------------------------------------------------------------
// rvfi_retire_reorder
//   Multi-lane RVFI retirement reorder buffer. Up to NRET retirement packets per
//   cycle arrive in any order, keyed by rvfi_order. They are re-emitted strictly
//   in ascending order, one per cycle, on a single registered output channel.
//   This lets superscalar or out-of-order retire taps feed in-order checkers.
//
//   Optional feature: define RVFI_REORDER_TIMEOUT_EN to build a head-stall
//   counter that raises the sticky 'timeout' flag. Without it, 'timeout' is 0.
//
// Ports
//   clock      sole clock, rising edge
//   reset      synchronous, active-high
//   in_valid   per-lane packet valid                  [NRET]
//   in_order   per-lane rvfi_order, lane i at [i*ORD_W +: ORD_W]
//   in_pkt     per-lane payload, lane i at [i*PKT_W +: PKT_W]
//   in_ready   all valid lanes accepted this cycle (combinational)
//   out_valid  in-order packet available
//   out_ready  consumer accepts the out packet
//   out_order  order of the out packet
//   out_pkt    payload of the out packet
//   err_order  sticky: duplicate / stale / colliding order seen
//   timeout    sticky: head stalled for TIMEOUT cycles
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The input side is all-or-nothing: when in_ready is low no lane is
// taken. out_* stay stable while out_valid is high and out_ready is low.
// -----------------------------------------------------------------------------
module rvfi_retire_reorder #(
  parameter int NRET    = 2,
  parameter int DEPTH   = 16,
  parameter int PKT_W   = 512,
  parameter int ORD_W   = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NRET-1:0]         in_valid,
  input  logic [NRET*ORD_W-1:0]   in_order,
  input  logic [NRET*PKT_W-1:0]   in_pkt,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ORD_W-1:0]        out_order,
  output logic [PKT_W-1:0]        out_pkt,
  output logic                    err_order,
  output logic                    timeout
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] slot_v;
  logic [DEPTH-1:0] slot_v_nxt;
  logic [PKT_W-1:0] slot_pkt [DEPTH];
  logic [ORD_W-1:0] head;
  logic [IDX_W-1:0] head_idx;
  logic             load;

  logic [ORD_W-1:0] lane_ord [NRET];
  logic [PKT_W-1:0] lane_pkt [NRET];
  logic [IDX_W-1:0] lane_idx [NRET];
  logic [ORD_W-1:0] lane_d   [NRET];
  logic [NRET-1:0]  lane_ok;
  logic [NRET-1:0]  lane_stale;
  logic [NRET-1:0]  lane_dup;
  logic [NRET-1:0]  lane_acc;
  logic [NRET-1:0]  lane_wr;
  logic [NRET-1:0]  lane_err;

  assign head_idx = head[IDX_W-1:0];

  // Per-lane window classification against the pre-increment head. A lane is
  // "ok" inside the window and "stale" in the upper half of the order space;
  // stale lanes are accepted and dropped so replays cannot deadlock the input.
  always_comb begin
    in_ready = 1'b1;
    for (int i = 0; i < NRET; i++) begin
      lane_ord[i]   = in_order[i*ORD_W +: ORD_W];
      lane_pkt[i]   = in_pkt[i*PKT_W +: PKT_W];
      lane_idx[i]   = lane_ord[i][IDX_W-1:0];
      lane_d[i]     = lane_ord[i] - head;
      lane_ok[i]    = lane_d[i] < ORD_W'(DEPTH);
      lane_stale[i] = lane_d[i][ORD_W-1];
      if (in_valid[i] && !lane_ok[i] && !lane_stale[i]) begin
        in_ready = 1'b0;
      end
    end
  end

  // Collision resolution: the lowest lane carrying a given order wins. Inside
  // the window an occupied slot can only hold the same order, so an occupied
  // slot is always a duplicate.
  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      lane_dup[i] = 1'b0;
      for (int j = 0; j < NRET; j++) begin
        if (j < i && in_valid[j] && lane_ord[j] == lane_ord[i]) begin
          lane_dup[i] = 1'b1;
        end
      end
      lane_acc[i] = in_valid[i] & in_ready;
      lane_wr[i]  = lane_acc[i] & lane_ok[i] & ~lane_dup[i] & ~slot_v[lane_idx[i]];
      lane_err[i] = lane_acc[i] &
                    (lane_stale[i] | lane_dup[i] | (lane_ok[i] & slot_v[lane_idx[i]]));
    end
  end

  assign load = (~out_valid | out_ready) & slot_v[head_idx];

  // A write never targets the head slot while it is being loaded: an order
  // equal to head would find the slot occupied and be dropped as a duplicate.
  always_comb begin
    slot_v_nxt = slot_v;
    for (int i = 0; i < NRET; i++) begin
      if (lane_wr[i]) begin
        slot_v_nxt[lane_idx[i]] = 1'b1;
      end
    end
    if (load) begin
      slot_v_nxt[head_idx] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      slot_v    <= '0;
      out_valid <= 1'b0;
      out_order <= '0;
      out_pkt   <= '0;
      err_order <= 1'b0;
    end else begin
      slot_v <= slot_v_nxt;
      if (load) begin
        out_valid <= 1'b1;
        out_order <= head;
        out_pkt   <= slot_pkt[head_idx];
        head      <= head + ORD_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (|lane_err) begin
        err_order <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset; slot_v qualifies every entry.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NRET; i++) begin
      if (lane_wr[i]) begin
        slot_pkt[lane_idx[i]] <= lane_pkt[i];
      end
    end
  end

`ifdef RVFI_REORDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_cnt_nxt;
  logic             stall;

  // Stalled: something is buffered but the head packet has not arrived.
  assign stall = (|slot_v) & ~slot_v[head_idx];

  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (load) begin
      stall_cnt_nxt = '0;
    end else if (stall && stall_cnt != CNT_W'(TIMEOUT)) begin
      stall_cnt_nxt = stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt == CNT_W'(TIMEOUT)) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_retire_reorder.sv
// -----------------------------------------------------------------------------
// tb_rvfi_retire_reorder
//   Directed bench for rvfi_retire_reorder (NRET=2, DEPTH=16, PKT_W=32,
//   ORD_W=64, TIMEOUT=8). Inputs are driven 1 time unit after the rising edge;
//   outputs are sampled a further time unit later. Expected payloads are
//   rebuilt from the lane and order via mkpkt().
// -----------------------------------------------------------------------------
module tb_rvfi_retire_reorder;

  localparam int NRET    = 2;
  localparam int DEPTH   = 16;
  localparam int PKT_W   = 32;
  localparam int ORD_W   = 64;
  localparam int TIMEOUT = 8;

  logic                  clock;
  logic                  reset;
  logic [NRET-1:0]       in_valid;
  logic [NRET*ORD_W-1:0] in_order;
  logic [NRET*PKT_W-1:0] in_pkt;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [ORD_W-1:0]      out_order;
  logic [PKT_W-1:0]      out_pkt;
  logic                  err_order;
  logic                  timeout;

  int total = 0;
  int bad   = 0;

  rvfi_retire_reorder #(
    .NRET(NRET), .DEPTH(DEPTH), .PKT_W(PKT_W), .ORD_W(ORD_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_order(in_order), .in_pkt(in_pkt), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_pkt(out_pkt), .err_order(err_order), .timeout(timeout)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [PKT_W-1:0] mkpkt(input int lane, input logic [ORD_W-1:0] ord);
    return 32'hA000_0000 | (32'(lane) << 24) | {8'h00, ord[23:0]};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [ORD_W-1:0] ord);
    in_valid[lane]                 = 1'b1;
    in_order[lane*ORD_W +: ORD_W]  = ord;
    in_pkt[lane*PKT_W +: PKT_W]    = mkpkt(lane, ord);
  endtask

  task automatic clr();
    in_valid = '0;
    in_order = '0;
    in_pkt   = '0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    clr();
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [ORD_W-1:0] ord, input logic [PKT_W-1:0] pkt);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_order"}, out_order, ord);
    chk({tag, "_pkt"}, 64'(out_pkt), 64'(pkt));
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    clr();

    // ---- reset state ----
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_order", out_order, 64'd0);
    chk("rst_out_pkt", 64'(out_pkt), 64'd0);
    chk("rst_err", 64'(err_order), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // ---- 1: in-order single lane ----
    for (int k = 0; k < 34; k++) begin
      clr();
      if (k < 32) set_lane(0, 64'(k));
      #1;
      chk("t1_in_ready", 64'(in_ready), 64'd1);
      tick();
      if (k == 0 || k == 33) chk("t1_idle", 64'(out_valid), 64'd0);
      else chk_out("t1_out", 64'(k - 1), mkpkt(0, 64'(k - 1)));
    end
    chk("t1_err", 64'(err_order), 64'd0);

    // ---- 2: swapped lanes ----
    do_reset();
    clr(); set_lane(0, 64'd1); set_lane(1, 64'd0);
    tick();
    chk("t2_first", 64'(out_valid), 64'd0);
    clr(); set_lane(0, 64'd3); set_lane(1, 64'd2);
    tick();
    clr();
    chk_out("t2_o0", 64'd0, mkpkt(1, 64'd0));
    tick(); chk_out("t2_o1", 64'd1, mkpkt(0, 64'd1));
    tick(); chk_out("t2_o2", 64'd2, mkpkt(1, 64'd2));
    tick(); chk_out("t2_o3", 64'd3, mkpkt(0, 64'd3));
    tick(); chk("t2_end", 64'(out_valid), 64'd0);
    chk("t2_err", 64'(err_order), 64'd0);

    // ---- 3: window full ----
    do_reset();
    for (int k = 1; k < 16; k++) begin
      clr(); set_lane(0, 64'(k));
      #1;
      chk("t3_fill_ready", 64'(in_ready), 64'd1);
      tick();
    end
    chk("t3_no_head", 64'(out_valid), 64'd0);
    clr(); set_lane(0, 64'd16);
    #1;
    chk("t3_full_ready", 64'(in_ready), 64'd0);
    tick();
    clr(); set_lane(0, 64'd0); set_lane(1, 64'd16);
    #1;
    chk("t3_all_or_none", 64'(in_ready), 64'd0);
    clr(); set_lane(0, 64'd0);
    #1;
    chk("t3_head_ready", 64'(in_ready), 64'd1);
    tick();
    clr(); set_lane(0, 64'd16);
    #1;
    chk("t3_preinc_head", 64'(in_ready), 64'd0);
    tick();
    chk_out("t3_o0", 64'd0, mkpkt(0, 64'd0));
    chk("t3_16_ready", 64'(in_ready), 64'd1);
    tick();
    clr();
    chk_out("t3_o1", 64'd1, mkpkt(0, 64'd1));
    for (int j = 2; j <= 16; j++) begin
      tick();
      chk_out("t3_drain", 64'(j), mkpkt(0, 64'(j)));
    end
    tick();
    chk("t3_end", 64'(out_valid), 64'd0);
    chk("t3_err", 64'(err_order), 64'd0);

    // ---- 4: duplicate and stale ----
    do_reset();
    out_ready = 1'b0;
    clr(); set_lane(0, 64'd5); set_lane(1, 64'd5);
    tick();
    chk("t4_dup_err", 64'(err_order), 64'd1);
    chk("t4_dup_idle", 64'(out_valid), 64'd0);
    clr(); set_lane(0, 64'd0); set_lane(1, 64'd1); tick();
    clr(); set_lane(0, 64'd2); set_lane(1, 64'd3); tick();
    clr(); set_lane(0, 64'd4); tick();
    clr();
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk_out("t4_out", 64'(j), (j == 5) ? mkpkt(0, 64'd5) : mkpkt(j % 2, 64'(j)));
      tick();
    end
    chk("t4_after", 64'(out_valid), 64'd0);
    set_lane(0, 64'd5);
    #1;
    chk("t4_stale_ready", 64'(in_ready), 64'd1);
    tick();
    clr();
    chk("t4_stale_err", 64'(err_order), 64'd1);
    chk("t4_stale_idle", 64'(out_valid), 64'd0);
    tick();
    chk("t4_stale_dropped", 64'(out_valid), 64'd0);
    set_lane(1, 64'd6);
    tick();
    clr();
    tick();
    chk_out("t4_o6", 64'd6, mkpkt(1, 64'd6));

    // ---- 5: backpressure and reset mid-operation ----
    do_reset();
    out_ready = 1'b0;
    clr(); set_lane(0, 64'd0); set_lane(1, 64'd1); tick();
    clr(); set_lane(0, 64'd2); set_lane(1, 64'd3); tick();
    clr(); set_lane(0, 64'd4); set_lane(1, 64'd5); tick();
    clr();
    chk_out("t5_hold0", 64'd0, mkpkt(0, 64'd0));
    for (int n = 0; n < 10; n++) begin
      tick();
      chk_out("t5_hold", 64'd0, mkpkt(0, 64'd0));
    end
    reset = 1'b1;
    tick();
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_order", out_order, 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("t5_no_emit", 64'(out_valid), 64'd0);
    set_lane(1, 64'd0);
    tick();
    clr();
    chk("t5_lat", 64'(out_valid), 64'd0);
    tick();
    chk_out("t5_o0", 64'd0, mkpkt(1, 64'd0));
    tick();
    chk("t5_discarded", 64'(out_valid), 64'd0);
    chk("t5_err", 64'(err_order), 64'd0);

    // ---- 6: head stall ----
    do_reset();
    set_lane(0, 64'd1); set_lane(1, 64'd2);
    tick();
    clr();
    for (int n = 0; n < 7; n++) tick();
    chk("t6_before", 64'(timeout), 64'd0);
    tick();
`ifdef RVFI_REORDER_TIMEOUT_EN
    chk("t6_timeout", 64'(timeout), 64'd1);
`else
    chk("t6_timeout_off", 64'(timeout), 64'd0);
`endif
    chk("t6_no_out", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
